// File: rtl/joy_shift_reader.sv
// rtl/joy_shift_reader.sv - serial joystick/button shift-chain reader with whole-frame debounce
module joy_shift_reader #(
    parameter int NBITS     = 16,
    parameter int DIV       = 2,
    parameter int DEBOUNCE  = 2,
    parameter int SYNC_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             joy_data,
    input  logic             sync_in,
    output logic             joy_clk,
    output logic             joy_load_n,
    output logic [NBITS-1:0] buttons,
    output logic             frame_valid,
    output logic             changed
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [7:0] DIV_LAST  = 8'(DIV - 1);
    localparam logic [4:0] IDX_LAST  = 5'(NBITS - 1);
    localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE);

    logic [1:0]       state;
    logic [7:0]       div_cnt;
    logic             tick;
    logic [4:0]       idx;
    logic             load_second;
    logic [NBITS-1:0] raw;
    logic [NBITS-1:0] candidate;
    logic [3:0]       stable_cnt;
    logic             sync_d;
    logic             sync_pending;
    logic             sync_rise;

    logic [NBITS-1:0] cand_nxt;
    logic [3:0]       cnt_nxt;
    logic             qualify;

    assign tick      = (div_cnt == DIV_LAST);
    assign sync_rise = sync_in & ~sync_d;

    // Free-running tick divider; the chain outputs only move on ticks.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= 8'd0;
        end else if (tick) begin
            div_cnt <= 8'd0;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    // Whole-frame debounce: next candidate/count and whether buttons should take it.
    always_comb begin
        cand_nxt = candidate;
        cnt_nxt  = stable_cnt;
        if (raw == candidate) begin
            if (stable_cnt >= DEB_LIMIT) begin
                cnt_nxt = DEB_LIMIT;
            end else begin
                cnt_nxt = stable_cnt + 4'd1;
            end
        end else begin
            cand_nxt = raw;
            cnt_nxt  = 4'd1;
        end
        qualify = (cnt_nxt >= DEB_LIMIT) && (cand_nxt != buttons);
    end

    // Frame sequencer: load pulse, shift/sample per bit, then one-cycle debounce commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            idx          <= 5'd0;
            load_second  <= 1'b0;
            joy_clk      <= 1'b0;
            joy_load_n   <= 1'b1;
            buttons      <= '1;
            raw          <= '1;
            candidate    <= '1;
            stable_cnt   <= 4'd0;
            frame_valid  <= 1'b0;
            changed      <= 1'b0;
            sync_d       <= 1'b0;
            sync_pending <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            changed     <= 1'b0;
            sync_d      <= sync_in;
            case (state)
                S_IDLE: begin
                    joy_load_n <= 1'b1;
                    joy_clk    <= 1'b0;
                    if (SYNC_MODE == 0) begin
                        if (tick) begin
                            state       <= S_LOAD;
                            joy_load_n  <= 1'b0;
                            load_second <= 1'b0;
                        end
                    end else begin
                        if (tick && sync_pending) begin
                            state        <= S_LOAD;
                            joy_load_n   <= 1'b0;
                            load_second  <= 1'b0;
                            sync_pending <= 1'b0;
                        end else if (sync_rise) begin
                            sync_pending <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    joy_clk <= 1'b0;
                    if (tick) begin
                        if (load_second) begin
                            joy_load_n <= 1'b1;
                            idx        <= 5'd0;
                            state      <= S_SHIFT;
                        end else begin
                            load_second <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (tick) begin
                        if (!joy_clk) begin
                            for (int i = 0; i < NBITS; i++) begin
                                if (idx == 5'(i)) begin
                                    raw[i] <= joy_data;
                                end
                            end
                            joy_clk <= 1'b1;
                        end else begin
                            joy_clk <= 1'b0;
                            if (idx == IDX_LAST) begin
                                state <= S_DONE;
                            end else begin
                                idx <= idx + 5'd1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    candidate   <= cand_nxt;
                    stable_cnt  <= cnt_nxt;
                    frame_valid <= 1'b1;
                    if (qualify) begin
                        buttons <= cand_nxt;
                        changed <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_joy_shift_reader.sv
// tb/tb_joy_shift_reader.sv - directed self-checking bench for joy_shift_reader
module tb_joy_shift_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // instance 0: 16 bits, DIV 2, free running
    logic        rst0 = 1'b1, jd0, jclk0, loadn0, fv0, chg0;
    logic [15:0] btn0, pat0 = 16'hFFFF, sr0 = 16'hFFFF;
    logic        jq0 = 1'b0, jp0 = 1'b0;
    int          per0 = 0, lastfv0 = 0, low0 = 0, low0_c = 0, pls0 = 0, pls0_c = 0, fvt0 = 0, ct0 = 0;

    // instance 1: 16 bits, DIV 2, sync mode
    logic        rst1 = 1'b1, jd1, sync1 = 1'b0, jclk1, loadn1, fv1, chg1;
    logic [15:0] btn1, pat1 = 16'hFFFF, sr1 = 16'hFFFF;
    logic        jq1 = 1'b0, jp1 = 1'b0;
    int          lowt1 = 0, pls1 = 0, pls1_c = 0, fvt1 = 0;

    // instance 2: 24 bits, DIV 5, free running
    logic        rst2 = 1'b1, jd2, jclk2, loadn2, fv2, chg2;
    logic [23:0] btn2, pat2 = 24'hFFFFFF, sr2 = 24'hFFFFFF;
    logic        jq2 = 1'b0, jp2 = 1'b0;
    int          per2 = 0, lastfv2 = 0, low2 = 0, low2_c = 0, pls2 = 0, pls2_c = 0;

    joy_shift_reader #(.NBITS(16), .DIV(2), .DEBOUNCE(2), .SYNC_MODE(0)) u0 (
        .clk(clk), .reset(rst0), .joy_data(jd0), .sync_in(1'b0), .joy_clk(jclk0),
        .joy_load_n(loadn0), .buttons(btn0), .frame_valid(fv0), .changed(chg0));
    joy_shift_reader #(.NBITS(16), .DIV(2), .DEBOUNCE(2), .SYNC_MODE(1)) u1 (
        .clk(clk), .reset(rst1), .joy_data(jd1), .sync_in(sync1), .joy_clk(jclk1),
        .joy_load_n(loadn1), .buttons(btn1), .frame_valid(fv1), .changed(chg1));
    joy_shift_reader #(.NBITS(24), .DIV(5), .DEBOUNCE(2), .SYNC_MODE(0)) u2 (
        .clk(clk), .reset(rst2), .joy_data(jd2), .sync_in(1'b0), .joy_clk(jclk2),
        .joy_load_n(loadn2), .buttons(btn2), .frame_valid(fv2), .changed(chg2));

    // shift-register chain models: parallel load while load_n low, shift on joy_clk rise
    assign jd0 = sr0[0];
    assign jd1 = sr1[0];
    assign jd2 = sr2[0];
    always @(posedge clk) begin
        if (!loadn0) sr0 <= pat0; else if (jclk0 && !jq0) sr0 <= sr0 >> 1;
        if (!loadn1) sr1 <= pat1; else if (jclk1 && !jq1) sr1 <= sr1 >> 1;
        if (!loadn2) sr2 <= pat2; else if (jclk2 && !jq2) sr2 <= sr2 >> 1;
        jq0 <= jclk0;
        jq1 <= jclk1;
        jq2 <= jclk2;
    end

    // per-frame monitors sampled on the falling edge
    always @(negedge clk) begin
        cyc <= cyc + 1;
        jp0 <= jclk0;
        jp1 <= jclk1;
        jp2 <= jclk2;
        if (rst0) begin
            low0_c <= 0; pls0_c <= 0;
        end else begin
            if (!loadn0) low0_c <= low0_c + 1;
            if (jclk0 && !jp0) pls0_c <= pls0_c + 1;
            if (fv0) begin
                per0 <= cyc - lastfv0; lastfv0 <= cyc;
                low0 <= low0_c; pls0 <= pls0_c; low0_c <= 0; pls0_c <= 0;
                fvt0 <= fvt0 + 1;
            end
        end
        if (chg0) ct0 <= ct0 + 1;
        if (!rst1) begin
            if (!loadn1) lowt1 <= lowt1 + 1;
            if (jclk1 && !jp1) pls1_c <= pls1_c + 1;
            if (fv1) begin
                pls1 <= pls1_c; pls1_c <= 0; fvt1 <= fvt1 + 1;
            end
        end
        if (!rst2) begin
            if (!loadn2) low2_c <= low2_c + 1;
            if (jclk2 && !jp2) pls2_c <= pls2_c + 1;
            if (fv2) begin
                per2 <= cyc - lastfv2; lastfv2 <= cyc;
                low2 <= low2_c; pls2 <= pls2_c; low2_c <= 0; pls2_c <= 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fv(input int which, input int budget, input string tag);
        int  n;
        logic hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            hit = (which == 0) ? fv0 : (which == 1) ? fv1 : fv2;
        end
        chk(tag, hit, 1);
    endtask

    initial begin
        int n;
        int fvb;
        logic hit;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_buttons", btn0, 16'hFFFF);
        chk("rst_fv", fv0, 0);
        chk("rst_changed", chg0, 0);
        chk("rst_joy_clk", jclk0, 0);
        chk("rst_load_n", loadn0, 1);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        // idle chain of all ones
        wait_fv(0, 200, "fv0_a");
        wait_fv(0, 200, "fv0_b");
        wait_fv(0, 200, "fv0_c");
        #1;
        chk("period16", per0, 70);
        chk("load_low16", low0, 4);
        chk("pulses16", pls0, 16);
        chk("ones_buttons", btn0, 16'hFFFF);
        chk("ones_changed", ct0, 0);

        // one-frame glitch of bit 3 must not pass debounce
        pat0 = 16'hFFF7;
        wait_fv(0, 200, "fv0_glitch");
        chk("glitch_f1", btn0, 16'hFFFF);
        pat0 = 16'hFFFF;
        wait_fv(0, 200, "fv0_g2");
        chk("glitch_f2", btn0, 16'hFFFF);
        wait_fv(0, 200, "fv0_g3");
        chk("glitch_f3", btn0, 16'hFFFF);
        #1;
        chk("glitch_changed", ct0, 0);

        // bit 7 held low for two frames
        pat0 = 16'hFF7F;
        wait_fv(0, 200, "fv0_p1");
        chk("press_f1", btn0, 16'hFFFF);
        wait_fv(0, 200, "fv0_p2");
        chk("press_f2", btn0, 16'hFF7F);
        chk("press_chg_pulse", chg0, 1);
        #1;
        chk("press_chg_count", ct0, 1);

        // reset while sampling bit index 9
        n = 0;
        while (pls0_c != 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("reach_idx9", pls0_c, 10);
        fvb = fvt0;
        rst0 = 1'b1;
        @(negedge clk);
        chk("midrst_buttons", btn0, 16'hFFFF);
        chk("midrst_joy_clk", jclk0, 0);
        chk("midrst_load_n", loadn0, 1);
        chk("midrst_fv", fv0, 0);
        rst0 = 1'b0;
        pat0 = 16'hA5C3;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 200) begin
            @(negedge clk);
            n++;
            hit = fv0;
        end
        chk("post_rst_first_fv_cycles", n, 71);
        chk("post_rst_buttons_f1", btn0, 16'hFFFF);
        #1;
        chk("post_rst_fv_count", fvt0, fvb + 1);
        wait_fv(0, 200, "fv0_r2");
        chk("post_rst_buttons_f2", btn0, 16'hA5C3);
        chk("post_rst_changed", chg0, 1);

        // 24-bit, DIV 5 instance has been running all along
        #1;
        chk("period24", per2, 255);
        chk("pulses24", pls2, 24);
        chk("load_low24", low2, 10);
        chk("buttons24", btn2, 24'hFFFFFF);

        // sync mode: nothing happens without sync_in
        chk("sync_idle_load_low", lowt1, 0);
        chk("sync_idle_load_n", loadn1, 1);
        chk("sync_idle_fv", fvt1, 0);
        sync1 = 1'b1;
        @(negedge clk);
        sync1 = 1'b0;
        n = 0;
        while (pls1_c < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("sync_in_shift", (pls1_c >= 3), 1);
        sync1 = 1'b1;
        @(negedge clk);
        sync1 = 1'b0;
        wait_fv(1, 200, "fv1_a");
        #1;
        chk("sync_fv_count1", fvt1, 1);
        chk("sync_pulses", pls1, 16);
        repeat (300) @(negedge clk);
        chk("sync_fv_count_after", fvt1, 1);
        chk("sync_load_low_total", lowt1, 4);
        chk("sync_buttons", btn1, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
